id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of PC, operand and immediate fields.
REQ-002 SHALL have parameter CNT_W, default 16: width of bubble counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port freeze  in  1  hold all state (memory-stage stall).
REQ-006 SHALL have port flush  in  1  branch taken in ID; discard the entry being captured.
REQ-007 SHALL have port hazard_detected  in  1  ID hazard; capture a bubble.
REQ-008 SHALL have ports EXE_CMD_IN  in  4, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each: decoded controls.
REQ-009 SHALL have ports PC_IN, reg1_IN, reg2_IN, val2_IN  in  DATA_W each: PC and operands (val2 immediate-selected).
REQ-010 SHALL have ports dest_IN, src1_IN, src2_IN  in  5 each: register addresses for writeback and forwarding.
REQ-011 SHALL have outputs EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, PC, reg1, reg2, val2, dest, src1, src2 of matching widths: registered copies.
REQ-012 SHALL have output valid  out  1  entry holds a real instruction.
REQ-013 SHALL have output bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Function
REQ-014 Per-edge priority SHALL be rst > freeze > flush > hazard_detected > normal load.
REQ-015 freeze=1 SHALL hold every output, including valid and bubble_cnt, unchanged; a coincident flush or hazard_detected SHALL be ignored.
REQ-016 flush=1 (freeze=0) SHALL load EXE_CMD=EXE_NO_OPERATION, WB_EN=MEM_R_EN=MEM_W_EN=0, valid=0, all data/address fields 0.
REQ-017 hazard_detected=1 (freeze=0, flush=0) SHALL load the same bubble as REQ-016.
REQ-018 Normal load SHALL copy every *_IN field to its output and set valid=1, latency exactly one cycle.
REQ-019 Each flush or hazard bubble load SHALL increment bubble_cnt by 1; at all-ones it SHALL saturate, never wrap.
REQ-020 Normal loads and frozen cycles SHALL leave bubble_cnt unchanged.
REQ-021 Outputs SHALL depend only on registered state (no combinational input-to-output path).
REQ-022 Control fields of a bubble SHALL be all-zero so EXE, MEM and WB perform no register or memory write.

Reset
REQ-023 rst=1 at an edge SHALL clear all outputs to 0 (EXE_CMD=EXE_NO_OPERATION), valid=0, bubble_cnt=0, regardless of freeze/flush.
REQ-024 Reset asserted mid-stream SHALL discard the held entry; first normal load after rst deasserts SHALL behave per REQ-018.

Structure
REQ-025 EXE_* command encodings and EXE_NO_OPERATION SHALL come from the shared defines file; no local redefinition.
REQ-026 A generic parameterised register sub-module "pipe_reg" (clk, rst, clear, hold, d, q) SHALL be instantiated per field group; bubble counter logic SHALL live in id_exe_reg.

Verification
REQ-027 Reset: rst=1 with all inputs nonzero -> next edge all outputs 0, valid=0, bubble_cnt=0.
REQ-028 Load: EXE_CMD_IN=4'b0010, WB_EN_IN=1, reg1_IN=32'h5, val2_IN=32'h7, dest_IN=3 -> one edge later same values, valid=1, bubble_cnt unchanged.
REQ-029 Freeze over flush: registered entry valid, freeze=1 and flush=1 for 3 cycles -> outputs and bubble_cnt constant; freeze=0, flush=1 -> bubble, bubble_cnt+1.
REQ-030 Hazard: hazard_detected=1 with MEM_W_EN_IN=1 -> MEM_W_EN=0, WB_EN=0, valid=0, bubble_cnt+1.
REQ-031 Saturation: CNT_W=4, 17 consecutive flushes -> bubble_cnt reaches 4'hF and stays 4'hF.
REQ-032 Reset mid-stream: after 2 bubbles, rst=1 with freeze=1 -> outputs 0, bubble_cnt=0.

Source files
------------

// File: rtl/id_exe_reg_pkg.sv
// Shared EXE command encodings and field widths for the ID/EXE pipeline boundary.
package id_exe_reg_pkg;

  localparam int unsigned EXE_CMD_W  = 4;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NO_OPERATION = 4'b0000,
    EXE_MOV          = 4'b0001,
    EXE_ADD          = 4'b0010,
    EXE_SUB          = 4'b0100,
    EXE_AND          = 4'b0110,
    EXE_OR           = 4'b0111,
    EXE_NOR          = 4'b1000,
    EXE_XOR          = 4'b1001,
    EXE_SLA          = 4'b1010,
    EXE_SRA          = 4'b1100,
    EXE_SRL          = 4'b1101
  } exe_cmd_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: reset > hold > clear > load, clear/reset value selectable.
module pipe_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (hold) begin
      data_d = data_q;
    end else if (clear) begin
      data_d = CLR_VAL;
    end else begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= CLR_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush/hazard bubble insertion and a
// saturating count of inserted bubbles.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  hazard_detected,
  input  logic [EXE_CMD_W-1:0]  EXE_CMD_IN,
  input  logic                  WB_EN_IN,
  input  logic                  MEM_R_EN_IN,
  input  logic                  MEM_W_EN_IN,
  input  logic [DATA_W-1:0]     PC_IN,
  input  logic [DATA_W-1:0]     reg1_IN,
  input  logic [DATA_W-1:0]     reg2_IN,
  input  logic [DATA_W-1:0]     val2_IN,
  input  logic [REG_ADDR_W-1:0] dest_IN,
  input  logic [REG_ADDR_W-1:0] src1_IN,
  input  logic [REG_ADDR_W-1:0] src2_IN,
  output logic [EXE_CMD_W-1:0]  EXE_CMD,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic [DATA_W-1:0]     PC,
  output logic [DATA_W-1:0]     reg1,
  output logic [DATA_W-1:0]     reg2,
  output logic [DATA_W-1:0]     val2,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  valid,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned CTRL_W = EXE_CMD_W + 3;
  localparam int unsigned DAT_W  = 4 * DATA_W;
  localparam int unsigned ADDR_W = 3 * REG_ADDR_W;
  localparam logic [CTRL_W-1:0] CTRL_NOP = {EXE_NO_OPERATION, 3'b000};

  logic bubble;
  assign bubble = flush | hazard_detected;

  pipe_reg #(.W(CTRL_W), .CLR_VAL(CTRL_NOP)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .clear (bubble),
    .hold  (freeze),
    .d     ({EXE_CMD_IN, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN}),
    .q     ({EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN})
  );

  pipe_reg #(.W(DAT_W)) u_data (
    .clk   (clk),
    .rst   (rst),
    .clear (bubble),
    .hold  (freeze),
    .d     ({PC_IN, reg1_IN, reg2_IN, val2_IN}),
    .q     ({PC, reg1, reg2, val2})
  );

  pipe_reg #(.W(ADDR_W)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .clear (bubble),
    .hold  (freeze),
    .d     ({dest_IN, src1_IN, src2_IN}),
    .q     ({dest, src1, src2})
  );

  pipe_reg #(.W(1)) u_valid (
    .clk   (clk),
    .rst   (rst),
    .clear (bubble),
    .hold  (freeze),
    .d     (1'b1),
    .q     (valid)
  );

  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!freeze && bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized self-checking bench for id_exe_reg against a cycle-level reference model.
module tb_id_exe_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, freeze, flush, hazard_detected;
  logic [3:0]    EXE_CMD_IN;
  logic          WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [DW-1:0] PC_IN, reg1_IN, reg2_IN, val2_IN;
  logic [4:0]    dest_IN, src1_IN, src2_IN;
  logic [3:0]    EXE_CMD;
  logic          WB_EN, MEM_R_EN, MEM_W_EN;
  logic [DW-1:0] PC, reg1, reg2, val2;
  logic [4:0]    dest, src1, src2;
  logic          valid;
  logic [CW-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_exe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .hazard_detected(hazard_detected),
    .EXE_CMD_IN(EXE_CMD_IN), .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
    .MEM_W_EN_IN(MEM_W_EN_IN), .PC_IN(PC_IN), .reg1_IN(reg1_IN), .reg2_IN(reg2_IN),
    .val2_IN(val2_IN), .dest_IN(dest_IN), .src1_IN(src1_IN), .src2_IN(src2_IN),
    .EXE_CMD(EXE_CMD), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .PC(PC), .reg1(reg1), .reg2(reg2), .val2(val2), .dest(dest), .src1(src1),
    .src2(src2), .valid(valid), .bubble_cnt(bubble_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the instruction held in EXE plus a bubble tally.
  typedef struct {
    int unsigned cmd, wb, mr, mw, pc, r1, r2, v2, dst, s1, s2, vld;
  } entry_t;
  entry_t      m;
  int unsigned m_bubbles;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".EXE_CMD"},  64'(EXE_CMD),    64'(m.cmd));
    check_eq({tag, ".WB_EN"},    64'(WB_EN),      64'(m.wb));
    check_eq({tag, ".MEM_R_EN"}, 64'(MEM_R_EN),   64'(m.mr));
    check_eq({tag, ".MEM_W_EN"}, 64'(MEM_W_EN),   64'(m.mw));
    check_eq({tag, ".PC"},       64'(PC),         64'(m.pc));
    check_eq({tag, ".reg1"},     64'(reg1),       64'(m.r1));
    check_eq({tag, ".reg2"},     64'(reg2),       64'(m.r2));
    check_eq({tag, ".val2"},     64'(val2),       64'(m.v2));
    check_eq({tag, ".dest"},     64'(dest),       64'(m.dst));
    check_eq({tag, ".src1"},     64'(src1),       64'(m.s1));
    check_eq({tag, ".src2"},     64'(src2),       64'(m.s2));
    check_eq({tag, ".valid"},    64'(valid),      64'(m.vld));
    check_eq({tag, ".bubbles"},  64'(bubble_cnt), 64'(m_bubbles));
  endtask

  task automatic rand_fields();
    EXE_CMD_IN  = 4'($urandom);
    WB_EN_IN    = 1'($urandom);
    MEM_R_EN_IN = 1'($urandom);
    MEM_W_EN_IN = 1'($urandom);
    PC_IN       = $urandom;
    reg1_IN     = $urandom;
    reg2_IN     = $urandom;
    val2_IN     = $urandom;
    dest_IN     = 5'($urandom);
    src1_IN     = 5'($urandom);
    src2_IN     = 5'($urandom);
  endtask

  task automatic set_ctl(input logic r, input logic fz, input logic fl, input logic hz);
    rst = r; freeze = fz; flush = fl; hazard_detected = hz;
  endtask

  // Apply the pipeline rules to the model, clock once, then compare.
  task automatic step(input string tag);
    entry_t empty;
    empty = '{default: 0};
    if (rst) begin
      m = empty;
      m_bubbles = 0;
    end else if (freeze) begin
      // entry and tally unchanged
    end else if (flush || hazard_detected) begin
      m = empty;
      if (m_bubbles < (1 << CW) - 1) m_bubbles++;
    end else begin
      m = '{cmd: EXE_CMD_IN, wb: WB_EN_IN, mr: MEM_R_EN_IN, mw: MEM_W_EN_IN,
            pc: PC_IN, r1: reg1_IN, r2: reg2_IN, v2: val2_IN,
            dst: dest_IN, s1: src1_IN, s2: src2_IN, vld: 1};
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m = '{default: 0};
    m_bubbles = 0;

    // Reset with every input nonzero, freeze and flush also high.
    EXE_CMD_IN = 4'hF; WB_EN_IN = 1; MEM_R_EN_IN = 1; MEM_W_EN_IN = 1;
    PC_IN = '1; reg1_IN = '1; reg2_IN = '1; val2_IN = '1;
    dest_IN = '1; src1_IN = '1; src2_IN = '1;
    set_ctl(1, 1, 1, 1);
    step("reset");
    step("reset2");

    // Directed load.
    set_ctl(0, 0, 0, 0);
    rand_fields();
    EXE_CMD_IN = 4'b0010; WB_EN_IN = 1; reg1_IN = 32'h5; val2_IN = 32'h7; dest_IN = 5'd3;
    step("load");
    check_eq("load.dest3", 64'(dest), 64'd3);

    // Freeze dominates flush for three cycles, then flush alone inserts a bubble.
    for (int i = 0; i < 3; i++) begin
      set_ctl(0, 1, 1, 0);
      rand_fields();
      step("frz_over_flush");
    end
    check_eq("frz.valid_kept", 64'(valid), 64'd1);
    set_ctl(0, 0, 1, 0);
    step("flush_after_frz");
    check_eq("flush.cnt1", 64'(bubble_cnt), 64'd1);

    // Hazard bubble kills a store.
    set_ctl(0, 0, 0, 0);
    rand_fields();
    step("load2");
    set_ctl(0, 0, 0, 1);
    rand_fields();
    MEM_W_EN_IN = 1; WB_EN_IN = 1;
    step("hazard");
    check_eq("hazard.memw", 64'(MEM_W_EN), 64'd0);

    // Saturation: 17 consecutive flushes from a cleared counter.
    set_ctl(1, 0, 0, 0);
    step("pre_sat_rst");
    for (int i = 0; i < 17; i++) begin
      set_ctl(0, 0, 1, 0);
      rand_fields();
      step("sat");
    end
    check_eq("sat.cnt_F", 64'(bubble_cnt), 64'hF);
    set_ctl(0, 0, 0, 1);
    step("sat_hold");

    // Reset mid-stream after two bubbles, with freeze asserted.
    set_ctl(1, 0, 0, 0);
    step("pre_mid_rst");
    set_ctl(0, 0, 0, 0); rand_fields(); step("mid_load");
    set_ctl(0, 0, 1, 0); step("mid_b1");
    set_ctl(0, 0, 0, 1); step("mid_b2");
    set_ctl(0, 0, 0, 0); rand_fields(); step("mid_load2");
    set_ctl(1, 1, 0, 0); rand_fields(); step("mid_rst");
    set_ctl(0, 0, 0, 0); rand_fields(); step("post_rst_load");

    // Random traffic; inputs also change after the edge to expose any comb path.
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(99) < 2), ($urandom_range(99) < 20),
              ($urandom_range(99) < 15), ($urandom_range(99) < 15));
      rand_fields();
      step("rand");
      rand_fields();
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_eq("rand.comb_pc", 64'(PC), 64'(m.pc));
      check_eq("rand.comb_valid", 64'(valid), 64'(m.vld));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
